instr_sequencer: RTL

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
//
// Purpose:
//   Control sequencer for a small accumulator machine. Every instruction takes
//   three cycles: FETCH (ROM read strobe), LATCH (capture the ROM word into the
//   instruction register and advance the PC) and EXEC (decode the opcode and
//   pulse the datapath strobes). It can free-run or single-step, and it parks
//   in HALT until reset once it executes HLT.
//
// Ports:
//   clk        in   system clock, all state changes on the rising edge
//   rst        in   synchronous active-high reset
//   run        in   level, 1 = issue instructions back to back
//   step       in   one-cycle pulse, issues a single instruction from IDLE
//   rom_data   in   [7:0] ROM word, valid the cycle after rom_re
//                   ([7:4] opcode, [3:0] operand)
//   ab_flag    in   ALU comparison flag, condition for JC
//   rom_addr   out  [3:0] ROM address, mirrors pc
//   rom_re     out  ROM read strobe
//   pc         out  [3:0] program counter
//   imm        out  [3:0] operand field of the instruction register
//   a_we       out  A register write enable
//   a_sel      out  A source select, 0 = imm, 1 = ALU result
//   b_we       out  B register write enable
//   alu_sub    out  ALU operation, 0 = add, 1 = subtract
//   out_we     out  output register write enable
//   halted     out  high while parked in HALT
//   instr_done out  one-cycle pulse during every EXEC
// -----------------------------------------------------------------------------
module instr_sequencer #(
    parameter logic [3:0] RESET_PC = 4'h0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic       step,
    input  logic [7:0] rom_data,
    input  logic       ab_flag,
    output logic [3:0] rom_addr,
    output logic       rom_re,
    output logic [3:0] pc,
    output logic [3:0] imm,
    output logic       a_we,
    output logic       a_sel,
    output logic       b_we,
    output logic       alu_sub,
    output logic       out_we,
    output logic       halted,
    output logic       instr_done
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LATCH = 3'd2,
        S_EXEC  = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_LDB = 4'h2;
    localparam logic [3:0] OP_ADD = 4'h3;
    localparam logic [3:0] OP_SUB = 4'h4;
    localparam logic [3:0] OP_OUT = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_HLT = 4'h8;

    state_t     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [7:0] ir_q, ir_d;
    logic [3:0] opcode_s;
    logic       take_jump_s;

    assign opcode_s = ir_q[7:4];
    // JMP always redirects; JC only when the flag is set during EXEC.
    assign take_jump_s = (opcode_s == OP_JMP) || ((opcode_s == OP_JC) && ab_flag);

    // State, program counter and instruction register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            pc_q    <= RESET_PC;
            ir_q    <= 8'h00;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    // Next-state, next-PC and next-IR selection.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        case (state_q)
            S_IDLE: begin
                // step only counts here; outside IDLE it is dropped, not queued
                if (run || step) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_FETCH: begin
                state_d = S_LATCH;
            end
            S_LATCH: begin
                ir_d    = rom_data;
                pc_d    = pc_q + 4'd1;   // 4-bit add wraps F -> 0
                state_d = S_EXEC;
            end
            S_EXEC: begin
                // a taken jump replaces the increment already done in LATCH
                if (take_jump_s) begin
                    pc_d = ir_q[3:0];
                end else begin
                    pc_d = pc_q;
                end
                if (opcode_s == OP_HLT) begin
                    state_d = S_HALT;
                end else if (run) begin
                    state_d = S_FETCH;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Moore output decode; strobes are suppressed whenever reset is asserted.
    always_comb begin
        rom_re     = 1'b0;
        a_we       = 1'b0;
        a_sel      = 1'b0;
        b_we       = 1'b0;
        alu_sub    = 1'b0;
        out_we     = 1'b0;
        instr_done = 1'b0;
        if (!rst) begin
            case (state_q)
                S_FETCH: begin
                    rom_re = 1'b1;
                end
                S_EXEC: begin
                    instr_done = 1'b1;
                    case (opcode_s)
                        OP_LDA: begin
                            a_we = 1'b1;
                        end
                        OP_LDB: begin
                            b_we = 1'b1;
                        end
                        OP_ADD: begin
                            a_we  = 1'b1;
                            a_sel = 1'b1;
                        end
                        OP_SUB: begin
                            a_we    = 1'b1;
                            a_sel   = 1'b1;
                            alu_sub = 1'b1;
                        end
                        OP_OUT: begin
                            out_we = 1'b1;
                        end
                        OP_NOP, OP_JMP, OP_JC, OP_HLT: begin
                            a_we = 1'b0;
                        end
                        default: begin
                            a_we = 1'b0;
                        end
                    endcase
                end
                default: begin
                    rom_re = 1'b0;
                end
            endcase
        end else begin
            rom_re     = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign halted   = (state_q == S_HALT);
    assign pc       = pc_q;
    assign rom_addr = pc_q;
    assign imm      = ir_q[3:0];

endmodule
